// File: rtl/regfile_mp.sv
// Clocked multi-port register file for the decode stage.
// One synchronous write port, NUM_RD combinational read ports, and a
// sequential zero sweep that runs after reset or on clr_req.
// Optional build macro: REGFILE_BYPASS_EN enables write-through forwarding
// of the write port onto matching read ports in the same cycle.
//
// Handshake: a write is accepted on a rising edge when wr_en=1 and ready=1;
// wr_en=1 while ready=0 discards the write and raises wr_drop for one cycle.
// While ready=0 every read port returns zero.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  output logic                     ready,
  output logic                     wr_drop,
  output logic                     dbg_state_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Sweep counter carries one extra bit so it can never fold into a second sweep.
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                ready_q, ready_d;
  logic                wr_drop_q, wr_drop_d;
  logic                wr_ok;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  // Next-state logic: sweep progress, clear requests and write acceptance.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_drop_d = 1'b0;
    wr_ok     = 1'b0;
    case (state_q)
      S_INIT: begin
        cnt_d     = cnt_q + CNT_ONE;
        wr_drop_d = wr_en;
        if (cnt_q == CNT_LAST) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        // Writes to a hardwired zero entry vanish without a drop indication.
        wr_ok = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
        if (clr_req) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == S_READY);
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Storage array: the sweep clears one entry per cycle, otherwise accepted writes land.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state_q == S_INIT) begin
        mem_q[cnt_q[ADDR_W-1:0]] <= '0;
      end else if (wr_ok) begin
        mem_q[wr_addr] <= wr_data;
      end
    end
  end

  // Read ports: zero-register and not-ready gating override any forwarded value.
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rv;
    rd_data = '0;
    ra      = '0;
    rv      = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      ra = rd_addr[k*ADDR_W +: ADDR_W];
      rv = mem_q[ra];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wr_addr == ra)) begin
        rv = wr_data;
      end
`endif
      if (!ready_q || ((ZERO_REG != 0) && (ra == '0))) begin
        rv = '0;
      end
      rd_data[k*DATA_W +: DATA_W] = rv;
    end
  end

  assign ready       = ready_q;
  assign wr_drop     = wr_drop_q;
  assign dbg_state_o = (state_q == S_READY);

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a default instance (32x32, 2 ports, $zero) and a
// small instance (8x16, 3 ports, no zero register) share clock and reset.
// A behavioural model of each tracks remaining sweep cycles and contents.
module tb_regfile_mp;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- default instance ----------------
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        clr_req;
  logic        ready;
  logic        wr_drop;
  logic        dbg_state;

  regfile_mp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .clr_req    (clr_req),
    .ready      (ready),
    .wr_drop    (wr_drop),
    .dbg_state_o(dbg_state)
  );

  // ---------------- small instance ----------------
  logic [8:0]  p_rd_addr;
  logic [47:0] p_rd_data;
  logic        p_wr_en;
  logic [2:0]  p_wr_addr;
  logic [15:0] p_wr_data;
  logic        p_clr_req;
  logic        p_ready;
  logic        p_wr_drop;
  logic        p_dbg_state;

  regfile_mp #(
    .DATA_W  (16),
    .ADDR_W  (3),
    .NUM_RD  (3),
    .ZERO_REG(0)
  ) dut_p (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (p_rd_addr),
    .rd_data    (p_rd_data),
    .wr_en      (p_wr_en),
    .wr_addr    (p_wr_addr),
    .wr_data    (p_wr_data),
    .clr_req    (p_clr_req),
    .ready      (p_ready),
    .wr_drop    (p_wr_drop),
    .dbg_state_o(p_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: cycles of sweep still to run, plus the visible contents.
  int          m_busy = 32;
  logic [31:0] m_mem [32];
  logic        m_drop = 1'b0;
  int          p_busy = 8;
  logic [15:0] p_mem [8];
  logic        p_drop = 1'b0;

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = '0;
    for (int i = 0; i < 8; i++) p_mem[i] = '0;
  end

  // Model update on each rising edge from the inputs held across that edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 32;
      m_drop = 1'b0;
      p_busy = 8;
      p_drop = 1'b0;
      chk_en = 1'b1;
    end else begin
      if (m_busy > 0) begin
        m_mem[32 - m_busy] = '0;
        m_drop = wr_en;
        m_busy--;
      end else begin
        m_drop = 1'b0;
        if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
        if (clr_req) m_busy = 32;
      end
      if (p_busy > 0) begin
        p_mem[8 - p_busy] = '0;
        p_drop = p_wr_en;
        p_busy--;
      end else begin
        p_drop = 1'b0;
        if (p_wr_en) p_mem[p_wr_addr] = p_wr_data;
        if (p_clr_req) p_busy = 8;
      end
    end
  end

  function automatic logic [31:0] m_rd(input int k);
    logic [4:0] a;
    a = rd_addr[k*5 +: 5];
    if (m_busy != 0 || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic [15:0] p_rd(input int k);
    logic [2:0] a;
    a = p_rd_addr[k*3 +: 3];
    if (p_busy != 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (p_wr_en && p_wr_addr == a) return p_wr_data;
`endif
    return p_mem[a];
  endfunction

  // Compare process: every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", ready, m_busy == 0);
      check("dbg_state", dbg_state, m_busy == 0);
      check("wr_drop", wr_drop, m_drop);
      for (int k = 0; k < 2; k++) check("rd_data", rd_data[k*32 +: 32], m_rd(k));
      check("p_ready", p_ready, p_busy == 0);
      check("p_wr_drop", p_wr_drop, p_drop);
      for (int k = 0; k < 3; k++) check("p_rd_data", p_rd_data[k*16 +: 16], p_rd(k));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en     = 1'b0;
    clr_req   = 1'b0;
    p_wr_en   = 1'b0;
    p_clr_req = 1'b0;
  endtask

  // Cycles from 'start' until ready is seen high; -1 if the budget runs out.
  task automatic wait_ready(input int start, output int n);
    n = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready) begin
        n = cyc - start;
        break;
      end
    end
  endtask

  // ---------------- stimulus ----------------
  int t0;
  int n;
  int m_at;
  int p_at;

  initial begin
    rst_n     = 1'b0;
    rd_addr   = '0;
    wr_addr   = '0;
    wr_data   = '0;
    p_rd_addr = '0;
    p_wr_addr = '0;
    p_wr_data = '0;
    idle();

    // Reset for two edges, then time both sweeps.
    repeat (2) tick();
    rst_n = 1'b1;
    t0    = cyc;
    m_at  = -1;
    p_at  = -1;
    for (int i = 0; i < 200 && (m_at < 0 || p_at < 0); i++) begin
      @(negedge clk);
      if (ready && m_at < 0) m_at = cyc - t0;
      if (p_ready && p_at < 0) p_at = cyc - t0;
    end
    check("sweep_len", m_at, 32);
    check("p_sweep_len", p_at, 8);
    tick();

    // Every entry reads zero after the sweep.
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(i), 5'(i)};
      @(negedge clk);
      check("swept_zero", rd_data, 64'h0);
      tick();
    end

    // Write r5 while reading it: old value unless forwarding is built in.
    wr_en   = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hDEADBEEF;
    rd_addr = {5'd31, 5'd5};
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_r5", rd_data[31:0], 32'hDEADBEEF);
`else
    check("same_cycle_r5", rd_data[31:0], 32'h0);
`endif
    tick();
    wr_addr = 5'd31;
    wr_data = 32'h12345678;
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    check("r5_r31", rd_data, {32'h12345678, 32'hDEADBEEF});
    tick();

    // Writing the zero register is ignored without a drop.
    wr_en   = 1'b1;
    wr_addr = 5'd0;
    wr_data = 32'hFFFFFFFF;
    rd_addr = {5'd5, 5'd0};
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    check("r0_read", rd_data[31:0], 32'h0);
    check("r0_no_drop", wr_drop, 1'b0);
    tick();

    // Small instance: all three ports on r7, and r0 behaves as ordinary storage.
    p_wr_en   = 1'b1;
    p_wr_addr = 3'd7;
    p_wr_data = 16'hBEEF;
    tick();
    p_wr_en   = 1'b0;
    p_rd_addr = {3'd7, 3'd7, 3'd7};
    @(negedge clk);
    check("p_r7_all_ports", p_rd_data, 48'hBEEFBEEFBEEF);
    tick();
    p_wr_en   = 1'b1;
    p_wr_addr = 3'd0;
    p_wr_data = 16'hFFFF;
    tick();
    p_wr_en   = 1'b0;
    p_rd_addr = {3'd7, 3'd7, 3'd0};
    @(negedge clk);
    check("p_r0_plain", p_rd_data[15:0], 16'hFFFF);
    check("p_r0_no_drop", p_wr_drop, 1'b0);
    tick();

    // Load r1..r4, request a clear, drop a write mid-sweep.
    for (int r = 1; r <= 4; r++) begin
      wr_en   = 1'b1;
      wr_addr = 5'(r);
      wr_data = 32'h11111111 * 32'(r);
      tick();
    end
    wr_en   = 1'b0;
    rd_addr = {5'd2, 5'd1};
    @(negedge clk);
    check("r1_loaded", rd_data[31:0], 32'h11111111);
    tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    t0      = cyc;
    @(negedge clk);
    check("clr_ready_low", ready, 1'b0);
    tick();
    while (cyc < t0 + 9) tick();
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'hA5A5A5A5;
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    check("drop_pulse", wr_drop, 1'b1);
    wait_ready(t0, n);
    check("clr_sweep_len", n, 32);
    tick();
    rd_addr = {5'd2, 5'd1};
    @(negedge clk);
    check("r1_r2_cleared", rd_data, 64'h0);
    tick();
    rd_addr = {5'd4, 5'd3};
    @(negedge clk);
    check("r3_r4_cleared", rd_data, 64'h0);
    tick();

    // Reset in the middle of a sweep restarts it in full.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    t0      = cyc;
    while (cyc < t0 + 15) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    t0    = cyc;
    wait_ready(t0, n);
    check("rst_mid_sweep_len", n, 32);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      wr_data   = $urandom;
      rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      clr_req   = ($urandom_range(0, 199) == 0);
      p_wr_en   = 1'($urandom_range(0, 1));
      p_wr_addr = 3'($urandom_range(0, 7));
      p_wr_data = 16'($urandom);
      p_rd_addr = 9'($urandom);
      p_clr_req = ($urandom_range(0, 99) == 0);
      rst_n     = ($urandom_range(0, 499) != 0);
      tick();
    end
    idle();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
